// File: rtl/mag_seq_if.sv
// Handshake and operand/result bundle for the nibble-serial magnitude comparator.
// The master side drives a request and the slave side (mag_seq) returns busy/ack and the result.
interface mag_seq_if #(
  parameter int NIBBLES = 8
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         signed_cmp;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         clr;
  logic         busy;
  logic         ack;
  logic         gt;
  logic         eq;
  logic         lt;

  modport master (
    output start, signed_cmp, a, b, clr,
    input  busy, ack, gt, eq, lt
  );

  modport slave (
    input  start, signed_cmp, a, b, clr,
    output busy, ack, gt, eq, lt
  );
endinterface

// File: rtl/mag_seq.sv
// Nibble-serial magnitude comparator: one 4-bit slice per clock, LSB nibble first,
// with unsigned and two's-complement modes; one result per NIBBLES+1 cycles back-to-back.
module mag_seq #(
  parameter int NIBBLES = 8
) (
  input  logic      sys_clk,
  input  logic      resetl,
  mag_seq_if.slave  bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IDXW-1:0]   r_idx;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_g;
  logic              r_e;
  logic              r_l;
  logic              r_gt;
  logic              r_eq;
  logic              r_lt;

  logic              w_accept;
  logic              w_last;
  logic              w_ng;
  logic              w_ne;
  logic              w_nl;
  logic [3:0]        w_na;
  logic [3:0]        w_nb;
  logic [W-1:0]      w_flip;

  // Flipping the sign bit maps two's-complement onto offset binary, so one unsigned slice serves both modes
  assign w_flip = {bus.signed_cmp, {(W-1){1'b0}}};

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = (r_idx == IDXW'(NIBBLES - 1));
    w_na     = r_a[3:0];
    w_nb     = r_b[3:0];
    w_ng     = r_g;
    w_ne     = r_e;
    w_nl     = r_l;

    // Higher nibbles arrive later, so a non-equal slice simply overwrites the history
    if (w_na > w_nb) begin
      w_ng = 1'b1;
      w_ne = 1'b0;
      w_nl = 1'b0;
    end else if (w_na < w_nb) begin
      w_ng = 1'b0;
      w_ne = 1'b0;
      w_nl = 1'b1;
    end

    if (bus.clr) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_next   = S_RUN;
            w_accept = 1'b1;
          end
        end
        S_RUN: begin
          if (w_last) begin
            w_next = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.start) begin
            w_next   = S_RUN;
            w_accept = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_idx <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_g   <= 1'b0;
      r_e   <= 1'b0;
      r_l   <= 1'b0;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else if (bus.clr) begin
      r_idx <= '0;
    end else if (w_accept) begin
      r_a   <= bus.a ^ w_flip;
      r_b   <= bus.b ^ w_flip;
      r_g   <= 1'b0;
      r_e   <= 1'b1;
      r_l   <= 1'b0;
      r_idx <= '0;
    end else if (r_state == S_RUN) begin
      r_a <= {4'b0000, r_a[W-1:4]};
      r_b <= {4'b0000, r_b[W-1:4]};
      r_g <= w_ng;
      r_e <= w_ne;
      r_l <= w_nl;
      if (w_last) begin
        r_gt <= w_ng;
        r_eq <= w_ne;
        r_lt <= w_nl;
      end else begin
        r_idx <= r_idx + IDXW'(1);
      end
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.ack  = (r_state == S_DONE);
  assign bus.gt   = r_gt;
  assign bus.eq   = r_eq;
  assign bus.lt   = r_lt;
endmodule

// File: tb/tb_mag_seq.sv
// Self-checking bench for mag_seq: directed scenarios plus a randomized regression
// compared against a plain-arithmetic reference of >, ==, < for both signedness modes.
module tb_mag_seq;
  localparam int NIBBLES = 8;
  localparam int W       = 4 * NIBBLES;
  localparam int BOUND   = 100;

  logic sysClk = 1'b0;
  logic resetl;
  int   checks   = 0;
  int   errors   = 0;
  int   ackCount = 0;

  mag_seq_if #(.NIBBLES(NIBBLES)) bus ();

  mag_seq #(.NIBBLES(NIBBLES)) dut (
    .sys_clk (sysClk),
    .resetl  (resetl),
    .bus     (bus.slave)
  );

  always #5 sysClk = ~sysClk;

  // Independent tally of every ack cycle, used to catch missing or extra acks
  always @(posedge sysClk) begin
    #1;
    if (bus.ack === 1'b1) ackCount++;
  end

  function automatic logic [2:0] refCompare(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
    if (s) begin
      if ($signed(a) > $signed(b)) return 3'b100;
      if ($signed(a) < $signed(b)) return 3'b001;
      return 3'b010;
    end
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    return 3'b010;
  endfunction

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  // Issues one start and waits (bounded) for ack; leaves the bench in the ack cycle
  task automatic doCompare(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           output logic [2:0] res, output int lat, output int busyCnt);
    bus.start      = 1'b1;
    bus.a          = a;
    bus.b          = b;
    bus.signed_cmp = s;
    tick();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    lat       = 0;
    busyCnt   = 0;
    while (bus.ack !== 1'b1 && lat < BOUND) begin
      if (bus.busy === 1'b1) busyCnt++;
      tick();
      lat++;
    end
    res = {bus.gt, bus.eq, bus.lt};
  endtask

  task automatic test_reset();
    resetl         = 1'b0;
    bus.start      = 1'b0;
    bus.clr        = 1'b0;
    bus.signed_cmp = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.ack, bus.gt, bus.eq, bus.lt} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000",
               {bus.busy, bus.ack, bus.gt, bus.eq, bus.lt});
    end
    @(negedge sysClk);
    resetl = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [2:0] res;
    int lat, busyCnt;
    doCompare(32'h12345678, 32'h12345679, 1'b0, res, lat, busyCnt);
    checks++;
    if (lat !== NIBBLES) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, NIBBLES);
    end
    checks++;
    if (busyCnt !== NIBBLES) begin
      errors++;
      $display("[TB] FAIL basic_busy_cycles: got %0d expected %0d", busyCnt, NIBBLES);
    end
    checks++;
    if (res !== 3'b001) begin
      errors++;
      $display("[TB] FAIL basic_result: got %b expected 001", res);
    end
    tick();
  endtask

  task automatic test_signed();
    logic [W-1:0] va [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [W-1:0] vb [3] = '{32'h00000001, 32'h00000001, 32'h7FFFFFFF};
    logic         vs [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0]   ex [3] = '{3'b100, 3'b001, 3'b001};
    logic [2:0] res;
    int lat, busyCnt;
    for (int i = 0; i < 3; i++) begin
      doCompare(va[i], vb[i], vs[i], res, lat, busyCnt);
      checks++;
      if (res !== ex[i]) begin
        errors++;
        $display("[TB] FAIL signed_case%0d: got %b expected %b", i, res, ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_equal_override();
    logic [2:0] res;
    int lat, busyCnt;
    doCompare(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, res, lat, busyCnt);
    checks++;
    if (res !== 3'b010) begin
      errors++;
      $display("[TB] FAIL equal_result: got %b expected 010", res);
    end
    tick();
    doCompare(32'h0000000F, 32'h10000000, 1'b0, res, lat, busyCnt);
    checks++;
    if (res !== 3'b001) begin
      errors++;
      $display("[TB] FAIL msb_override: got %b expected 001", res);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int base;
    int cnt;
    base           = ackCount;
    bus.start      = 1'b1;
    bus.a          = 32'h00000050;
    bus.b          = 32'h00000040;
    bus.signed_cmp = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.start = 1'b1;
    bus.a     = 32'h00000001;
    bus.b     = 32'hF0000000;
    repeat (2) tick();
    bus.start = 1'b0;
    cnt = 0;
    while (bus.ack !== 1'b1 && cnt < BOUND) begin
      tick();
      cnt++;
    end
    checks++;
    if ({bus.gt, bus.eq, bus.lt} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL busy_start_ignored: got %b expected 100", {bus.gt, bus.eq, bus.lt});
    end
    repeat (20) tick();
    checks++;
    if (ackCount - base !== 1) begin
      errors++;
      $display("[TB] FAIL busy_start_ack_count: got %0d expected 1", ackCount - base);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] res;
    int lat, busyCnt, gap;
    doCompare(32'h00000001, 32'h00000002, 1'b0, res, lat, busyCnt);
    bus.start = 1'b1;
    bus.a     = 32'h9ABCDEF0;
    bus.b     = 32'h9ABCDEF0;
    gap = 0;
    do begin
      tick();
      gap++;
      bus.start = 1'b0;
    end while (bus.ack !== 1'b1 && gap < BOUND);
    checks++;
    if (gap !== NIBBLES + 1) begin
      errors++;
      $display("[TB] FAIL b2b_ack_gap: got %0d expected %0d", gap, NIBBLES + 1);
    end
    checks++;
    if ({bus.gt, bus.eq, bus.lt} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL b2b_second_result: got %b expected 010", {bus.gt, bus.eq, bus.lt});
    end
    tick();
  endtask

  task automatic test_clr();
    logic [2:0] res;
    int lat, busyCnt, base;
    doCompare(32'h00000050, 32'h00000040, 1'b0, res, lat, busyCnt);
    tick();
    base           = ackCount;
    bus.start      = 1'b1;
    bus.a          = 32'h00000001;
    bus.b          = 32'h00000002;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    checks++;
    if ({bus.busy, bus.ack} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL clr_busy_ack: got %b expected 00", {bus.busy, bus.ack});
    end
    repeat (12) tick();
    checks++;
    if (ackCount - base !== 0) begin
      errors++;
      $display("[TB] FAIL clr_no_ack: got %0d acks expected 0", ackCount - base);
    end
    checks++;
    if ({bus.gt, bus.eq, bus.lt} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL clr_result_held: got %b expected 100", {bus.gt, bus.eq, bus.lt});
    end
    // A compare after the abort must run the full length from nibble 0
    doCompare(32'h00000003, 32'h00000002, 1'b0, res, lat, busyCnt);
    checks++;
    if (lat !== NIBBLES || res !== 3'b100) begin
      errors++;
      $display("[TB] FAIL clr_recover: got lat %0d res %b expected lat %0d res 100",
               lat, res, NIBBLES);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.start      = 1'b1;
    bus.a          = 32'h00000001;
    bus.b          = 32'h00000009;
    bus.signed_cmp = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    #2;
    resetl = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.ack, bus.gt, bus.eq, bus.lt} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got %b expected 00000",
               {bus.busy, bus.ack, bus.gt, bus.eq, bus.lt});
    end
    @(negedge sysClk);
    resetl = 1'b1;
    repeat (12) tick();
    checks++;
    if ({bus.busy, bus.ack, bus.gt, bus.eq, bus.lt} !== 5'b00000) begin
      errors++;
      $display("[TB] FAIL reset_mid_idle: got %b expected 00000",
               {bus.busy, bus.ack, bus.gt, bus.eq, bus.lt});
    end
  endtask

  task automatic test_random();
    localparam int ITER = 3000;
    logic [W-1:0] a, b;
    logic         s;
    logic [2:0]   res, exp;
    int lat, busyCnt, base, mode, nib;
    logic [W-1:0] specials [4] = '{32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};
    base = ackCount;
    for (int i = 0; i < ITER; i++) begin
      mode = $urandom_range(0, 3);
      a    = $urandom;
      b    = $urandom;
      s    = 1'($urandom_range(0, 1));
      if (mode == 1) begin
        b = a;
      end else if (mode == 2) begin
        nib = $urandom_range(0, NIBBLES - 1);
        b   = a;
        b[nib*4 +: 4] = 4'($urandom);
      end else if (mode == 3) begin
        a = specials[$urandom_range(0, 3)];
        b = specials[$urandom_range(0, 3)];
      end
      exp = refCompare(a, b, s);
      doCompare(a, b, s, res, lat, busyCnt);
      checks++;
      if (res !== exp) begin
        errors++;
        $display("[TB] FAIL rand_result: a=%h b=%h s=%b got %b expected %b", a, b, s, res, exp);
      end
      checks++;
      if (!$onehot(res)) begin
        errors++;
        $display("[TB] FAIL rand_onehot: got %b expected one-hot", res);
      end
      checks++;
      if (lat !== NIBBLES) begin
        errors++;
        $display("[TB] FAIL rand_latency: got %0d expected %0d", lat, NIBBLES);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    repeat (2) tick();
    checks++;
    if (ackCount - base !== ITER) begin
      errors++;
      $display("[TB] FAIL rand_ack_count: got %0d expected %0d", ackCount - base, ITER);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_equal_override();
    test_start_while_busy();
    test_back_to_back();
    test_clr();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
